// File: rtl/pic_pkg.sv
// Shared types and bit positions for the PIC bus controller.
// FSM states, ICW/OCW field positions and read-select encoding.
package pic_pkg;

  typedef enum logic [2:0] {
    S_UNINIT,
    S_WAIT_ICW2,
    S_WAIT_ICW3,
    S_WAIT_ICW4,
    S_READY
  } pic_state_e;

  typedef enum logic {
    RD_IRR = 1'b0,
    RD_ISR = 1'b1
  } rd_sel_e;

  // ICW1 fields
  localparam int ICW_FLAG_BIT = 4;
  localparam int LTIM_BIT     = 3;
  localparam int SNGL_BIT     = 1;
  localparam int IC4_BIT      = 0;
  // ICW4 fields
  localparam int SFNM_BIT     = 4;
  localparam int AEOI_BIT     = 1;
  // OCW3 fields
  localparam int OCW3_BIT     = 3;
  localparam int SMM_EN_BIT   = 6;
  localparam int SMM_BIT      = 5;
  localparam int POLL_BIT     = 2;
  localparam int RSEL_EN_BIT  = 1;
  localparam int RSEL_BIT     = 0;

endpackage

// File: rtl/pic_strobe_sync.sv
// Synchroniser for one asynchronous active-low strobe plus edge detect.
// Ports: clk, rst_n, strobe_n in; sync_n, rise, fall out.
module pic_strobe_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_n,
  output logic sync_n,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], strobe_n};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_n = chain[STAGES-1];
  assign rise   = sync_n & ~prev;
  assign fall   = ~sync_n & prev;

endmodule

// File: rtl/pic_bus_ctrl.sv
// 8259A-style CPU bus front end: strobe sync, ICW init FSM, OCW regs, read mux.
// Ports: CPU bus (CS_N/RD_N/WR_N/A0/DIN/DOUT), priority-block status in, control regs out.
module pic_bus_ctrl
  import pic_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CS_N,
  input  logic               RD_N,
  input  logic               WR_N,
  input  logic               A0,
  input  logic [7:0]         DIN,
  input  logic [NUM_IRQ-1:0] IRR,
  input  logic [NUM_IRQ-1:0] ISR,
  input  logic               INT_PEND,
  input  logic [2:0]         PRIO_LVL,
  output logic [7:0]         DOUT,
  output logic               DOUT_EN,
  output logic               INIT_DONE,
  output logic               LTIM,
  output logic               SNGL,
  output logic [4:0]         VEC_BASE,
  output logic [7:0]         ICW3_VAL,
  output logic               AEOI,
  output logic               SFNM,
  output logic [NUM_IRQ-1:0] IMR,
  output logic               SMM,
  output logic               OCW2_STB,
  output logic [7:0]         OCW2_CMD,
  output logic               POLL_ACK
);

  logic rd_s, rd_rise, rd_fall;
  logic wr_s, wr_rise, wr_fall;

  pic_strobe_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_rd (
    .clk      (CLK),
    .rst_n    (RST_N),
    .strobe_n (RD_N),
    .sync_n   (rd_s),
    .rise     (rd_rise),
    .fall     (rd_fall)
  );

  // Held "asserted" through reset so a strobe still low when reset
  // releases never produces a fall edge and is never captured.
  pic_strobe_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_wr (
    .clk      (CLK),
    .rst_n    (RST_N),
    .strobe_n (WR_N),
    .sync_n   (wr_s),
    .rise     (wr_rise),
    .fall     (wr_fall)
  );

  pic_state_e state_q, state_d;
  rd_sel_e    rd_sel;
  logic       poll_req;
  logic       ic4;
  logic       in_wr, cap_valid, cap_a0;
  logic [7:0] cap_d;
  logic       cmt, cmt_a0;
  logic [7:0] cmt_d;
  logic       in_rd;

  // Write capture: sampled every cycle of a selected strobe,
  // committed one cycle after the synced rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_wr     <= 1'b0;
      cap_valid <= 1'b0;
      cap_a0    <= 1'b0;
      cap_d     <= 8'h00;
      cmt       <= 1'b0;
      cmt_a0    <= 1'b0;
      cmt_d     <= 8'h00;
    end else begin
      cmt <= wr_rise & cap_valid;
      if (wr_fall) in_wr <= 1'b1;
      if (!wr_s && !CS_N && (in_wr || wr_fall)) begin
        cap_valid <= 1'b1;
        cap_a0    <= A0;
        cap_d     <= DIN;
      end
      if (wr_rise) begin
        in_wr     <= 1'b0;
        cap_valid <= 1'b0;
        cmt_a0    <= cap_a0;
        cmt_d     <= cap_d;
      end
    end
  end

  logic is_icw1, ready;
  logic ld_icw2, ld_icw3, ld_icw4;
  logic ocw1, ocw2, ocw3;

  assign ready   = (state_q == S_READY);
  assign is_icw1 = cmt & ~cmt_a0 & cmt_d[ICW_FLAG_BIT];
  assign ld_icw2 = cmt & cmt_a0 & (state_q == S_WAIT_ICW2);
  assign ld_icw3 = cmt & cmt_a0 & (state_q == S_WAIT_ICW3);
  assign ld_icw4 = cmt & cmt_a0 & (state_q == S_WAIT_ICW4);
  assign ocw1    = cmt & ready & cmt_a0;
  assign ocw2    = cmt & ready & ~cmt_a0 & ~cmt_d[ICW_FLAG_BIT] & ~cmt_d[OCW3_BIT];
  assign ocw3    = cmt & ready & ~cmt_a0 & ~cmt_d[ICW_FLAG_BIT] & cmt_d[OCW3_BIT];

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      is_icw1: state_d = S_WAIT_ICW2;
      ld_icw2: begin
        if (!SNGL)    state_d = S_WAIT_ICW3;
        else if (ic4) state_d = S_WAIT_ICW4;
        else          state_d = S_READY;
      end
      ld_icw3: state_d = ic4 ? S_WAIT_ICW4 : S_READY;
      ld_icw4: state_d = S_READY;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_UNINIT;
    else        state_q <= state_d;
  end

  assign INIT_DONE = ready;

  logic poll_done;
  assign poll_done = rd_rise & in_rd & ~CS_N & ~A0 & poll_req;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LTIM     <= 1'b0;
      SNGL     <= 1'b0;
      ic4      <= 1'b0;
      VEC_BASE <= 5'h00;
      ICW3_VAL <= 8'h00;
      AEOI     <= 1'b0;
      SFNM     <= 1'b0;
      IMR      <= '0;
      SMM      <= 1'b0;
      OCW2_STB <= 1'b0;
      OCW2_CMD <= 8'h00;
      POLL_ACK <= 1'b0;
      poll_req <= 1'b0;
      rd_sel   <= RD_IRR;
      in_rd    <= 1'b0;
    end else begin
      OCW2_STB <= ocw2;
      POLL_ACK <= poll_done;
      if (rd_fall) in_rd <= 1'b1;
      if (rd_rise) in_rd <= 1'b0;
      if (poll_done) poll_req <= 1'b0;
      if (is_icw1) begin
        LTIM     <= cmt_d[LTIM_BIT];
        SNGL     <= cmt_d[SNGL_BIT];
        ic4      <= cmt_d[IC4_BIT];
        IMR      <= '0;
        SMM      <= 1'b0;
        AEOI     <= 1'b0;
        SFNM     <= 1'b0;
        poll_req <= 1'b0;
        rd_sel   <= RD_IRR;
      end
      if (ld_icw2) VEC_BASE <= cmt_d[7:3];
      if (ld_icw3) ICW3_VAL <= cmt_d;
      if (ld_icw4) begin
        AEOI <= cmt_d[AEOI_BIT];
        SFNM <= cmt_d[SFNM_BIT];
      end
      if (ocw1) IMR <= cmt_d[NUM_IRQ-1:0];
      if (ocw2) OCW2_CMD <= cmt_d;
      if (ocw3) begin
        if (cmt_d[RSEL_EN_BIT]) rd_sel <= rd_sel_e'(cmt_d[RSEL_BIT]);
        if (cmt_d[SMM_EN_BIT])  SMM <= cmt_d[SMM_BIT];
        if (cmt_d[POLL_BIT])    poll_req <= 1'b1;
      end
    end
  end

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    if (A0)
      rd_mux = 8'(IMR);
    else if (poll_req)
      rd_mux = {INT_PEND, 4'b0000, PRIO_LVL};
    else if (rd_sel == RD_ISR)
      rd_mux = 8'(ISR);
    else
      rd_mux = 8'(IRR);
  end

  assign DOUT_EN = ~rd_s & ~CS_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) DOUT <= 8'h00;
    else        DOUT <= DOUT_EN ? rd_mux : 8'h00;
  end

endmodule
